// File: rtl/n64_pi_bus_frontend.sv
// N64 PI bus front end: synchronises ALE_H/ALE_L/READ_N/AD, latches the cart
// address and prefetches one halfword per read over a req/ack memory port.
module n64_pi_bus_frontend #(
  parameter int MEM_AW      = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       n64_ad_i,
  input  logic              n64_ale_h,
  input  logic              n64_ale_l,
  input  logic              n64_read_n,
  output logic [15:0]       n64_ad_o,
  output logic              n64_ad_oe,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              underrun
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_PREFETCH = 3'd2,
    S_READY    = 3'd3,
    S_DRIVE    = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] ale_h_sync;
  logic [SYNC_STAGES-1:0] ale_l_sync;
  logic [SYNC_STAGES-1:0] read_n_sync;
  logic [15:0]            ad_sync [SYNC_STAGES];
  logic                   ale_h_prev;
  logic                   ale_l_prev;
  logic                   read_n_prev;

  logic        ale_h_rise;
  logic        ale_h_fall;
  logic        ale_l_fall;
  logic        read_fall;
  logic        read_rise;
  logic [15:0] ad_s;

  state_t      state;
  logic [31:0] addr;
  logic [15:0] buf_data;
  logic        buf_valid;
  logic        stale;
  logic        und_pend;
  logic        in_window;
  logic        ack_load;

  // AD goes through the same depth as the strobes so captured data lines up.
  always_ff @(posedge clock) begin
    if (reset) begin
      ale_h_sync  <= '0;
      ale_l_sync  <= '0;
      read_n_sync <= '1;
      ale_h_prev  <= 1'b0;
      ale_l_prev  <= 1'b0;
      read_n_prev <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) ad_sync[i] <= 16'h0000;
    end else begin
      ale_h_sync  <= {ale_h_sync[SYNC_STAGES-2:0], n64_ale_h};
      ale_l_sync  <= {ale_l_sync[SYNC_STAGES-2:0], n64_ale_l};
      read_n_sync <= {read_n_sync[SYNC_STAGES-2:0], n64_read_n};
      ale_h_prev  <= ale_h_sync[SYNC_STAGES-1];
      ale_l_prev  <= ale_l_sync[SYNC_STAGES-1];
      read_n_prev <= read_n_sync[SYNC_STAGES-1];
      ad_sync[0]  <= n64_ad_i;
      for (int i = 1; i < SYNC_STAGES; i++) ad_sync[i] <= ad_sync[i-1];
    end
  end

  assign ale_h_rise = ale_h_sync[SYNC_STAGES-1] & ~ale_h_prev;
  assign ale_h_fall = ~ale_h_sync[SYNC_STAGES-1] & ale_h_prev;
  assign ale_l_fall = ~ale_l_sync[SYNC_STAGES-1] & ale_l_prev;
  assign read_fall  = ~read_n_sync[SYNC_STAGES-1] & read_n_prev;
  assign read_rise  = read_n_sync[SYNC_STAGES-1] & ~read_n_prev;
  assign ad_s       = ad_sync[SYNC_STAGES-1];

  assign in_window = (addr >= 32'h1000_0000) && (addr < 32'h1FC0_0000);
  assign ack_load  = mem_req && mem_ack && !stale && (state == S_PREFETCH);

  // Bus FSM, memory port and registered AD outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      addr      <= 32'h0000_0000;
      buf_data  <= 16'h0000;
      buf_valid <= 1'b0;
      stale     <= 1'b0;
      und_pend  <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= {MEM_AW{1'b0}};
      n64_ad_o  <= 16'h0000;
      n64_ad_oe <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      n64_ad_oe <= (state == S_DRIVE) && in_window;
      n64_ad_o  <= buf_valid ? buf_data : 16'hFFFF;
      underrun  <= und_pend;
      und_pend  <= 1'b0;

      // Any ack retires the outstanding request; only a live one in PREFETCH loads data.
      if (mem_req && mem_ack) begin
        mem_req <= 1'b0;
        stale   <= 1'b0;
      end

      if (ale_h_rise) begin
        state     <= S_ADDR;
        buf_valid <= 1'b0;
        if (mem_req && !mem_ack) stale <= 1'b1;
      end else begin
        case (state)
          S_IDLE: state <= S_IDLE;
          S_ADDR: begin
            if (ale_h_fall) addr[31:16] <= ad_s;
            if (ale_l_fall) begin
              addr[15:0] <= ad_s;
              state      <= S_PREFETCH;
            end
          end
          S_PREFETCH: begin
            if (read_fall) begin
              state <= S_DRIVE;
              if (in_window) begin
                und_pend <= 1'b1;
                if (mem_req && !mem_ack) stale <= 1'b1;
              end
            end else if (ack_load) begin
              buf_data  <= mem_rdata;
              buf_valid <= 1'b1;
              state     <= S_READY;
            end else if (in_window && !mem_req) begin
              mem_req  <= 1'b1;
              mem_addr <= addr[MEM_AW:1];
            end
          end
          S_READY: begin
            if (read_fall) state <= S_DRIVE;
          end
          S_DRIVE: begin
            if (read_rise) begin
              addr      <= addr + 32'd2;
              buf_valid <= 1'b0;
              state     <= S_PREFETCH;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_n64_pi_bus_frontend.sv
// Randomised bench for n64_pi_bus_frontend: PI bus driver, memory responder with
// a data model, and a transaction-level model of address and read behaviour.
module tb_n64_pi_bus_frontend;

  logic        clock;
  logic        reset;
  logic [15:0] n64_ad_i;
  logic        n64_ale_h;
  logic        n64_ale_l;
  logic        n64_read_n;
  logic [15:0] n64_ad_o;
  logic        n64_ad_oe;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        underrun;

  n64_pi_bus_frontend #(.MEM_AW(24), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .n64_ad_i(n64_ad_i), .n64_ale_h(n64_ale_h),
    .n64_ale_l(n64_ale_l), .n64_read_n(n64_read_n), .n64_ad_o(n64_ad_o),
    .n64_ad_oe(n64_ad_oe), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .underrun(underrun)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] maddr = 32'h0;
  logic [23:0] exp_q[$];
  logic [23:0] req_log[$];
  int          slow_cnt = 0;
  int          slow_delay = 0;
  bit          force_ack = 1'b0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_model(input logic [23:0] h);
    if (h == 24'h000020) return 16'hBEEF;
    return h[15:0] ^ {h[23:16], h[7:0]} ^ 16'h3C5A;
  endfunction

  function automatic bit inwin(input logic [31:0] a);
    return (a >= 32'h1000_0000) && (a < 32'h1FC0_0000);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Memory responder: logs each request, acks after a chosen latency.
  initial begin : responder
    int          rs;
    int          cnt;
    logic [23:0] cur;
    rs = 0; cnt = 0; cur = 24'h0;
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    forever begin
      @(negedge clock);
      mem_ack = 1'b0;
      if (reset) begin
        rs = 0;
      end else begin
        if (force_ack) begin
          mem_ack = 1'b1; mem_rdata = 16'h1357; force_ack = 1'b0;
        end else if (rs == 2) begin
          rs = 0;
        end
        if (rs == 0 && mem_req && !mem_ack) begin
          cur = mem_addr;
          req_log.push_back(mem_addr);
          if (slow_cnt > 0) begin cnt = slow_delay; slow_cnt--; end
          else cnt = $urandom_range(0, 5);
          rs = 1;
        end
        if (rs == 1) begin
          if (cnt == 0) begin
            check_value("mem_addr_hold", {8'h0, mem_addr}, {8'h0, cur});
            mem_ack = 1'b1; mem_rdata = mem_model(cur); rs = 2;
          end else cnt--;
        end
      end
    end
  end

  task automatic set_addr(input logic [31:0] a, input bit low_only, input int trail);
    n64_ale_l = 1'b1; n64_ale_h = 1'b1;
    n64_ad_i = low_only ? 16'hDEAD : a[31:16];
    cycles(4);
    if (!low_only) begin n64_ale_h = 1'b0; cycles(4); end
    n64_ad_i = a[15:0];
    cycles(4);
    n64_ale_l = 1'b0;
    cycles(4);
    n64_ale_h = 1'b0;
    maddr = low_only ? {maddr[31:16], a[15:0]} : a;
    if (inwin(maddr)) exp_q.push_back(maddr[24:1]);
    cycles(trail);
  endtask

  task automatic read_pulse(input int low, input bit win, input bit und,
                            input logic [15:0] exp_d, input int gap);
    int          first_oe = -1;
    int          und_at = -1;
    int          und_n = 0;
    int          off = -1;
    logic [15:0] d = 16'h0;
    n64_read_n = 1'b0;
    for (int i = 1; i <= low; i++) begin
      @(negedge clock);
      if (n64_ad_oe && first_oe < 0) begin first_oe = i; d = n64_ad_o; end
      if (underrun) begin und_n++; und_at = i; end
    end
    n64_read_n = 1'b1;
    for (int i = 1; i <= gap; i++) begin
      @(negedge clock);
      if (!n64_ad_oe && off < 0) off = i;
      if (underrun) und_n++;
    end
    if (win) begin
      check_value("oe_rise_lat", first_oe, 32'd4);
      check_value("ad_o", {16'h0, d}, {16'h0, exp_d});
      check_value("oe_fall_lat", off, 32'd4);
    end else begin
      check_value("oe_never", first_oe, 32'hFFFF_FFFF);
    end
    check_value("underrun_cnt", und_n, und ? 32'd1 : 32'd0);
    if (und) check_value("underrun_align", und_at, first_oe);
  endtask

  task automatic do_burst(input int n);
    for (int k = 0; k < n; k++) begin
      read_pulse($urandom_range(6, 12), inwin(maddr), 1'b0, mem_model(maddr[24:1]),
                 $urandom_range(14, 20));
      maddr = maddr + 32'd2;
      if (inwin(maddr)) exp_q.push_back(maddr[24:1]);
    end
  endtask

  task automatic check_reqs();
    cycles(12);
    check_value("req_count", req_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < req_log.size(); i++)
      check_value("req_addr", {8'h0, req_log[i]}, {8'h0, exp_q[i]});
    exp_q.delete();
    req_log.delete();
  endtask

  initial begin : main
    bit seen;
    reset = 1'b1; n64_ad_i = 16'h0; n64_ale_h = 1'b0; n64_ale_l = 1'b0; n64_read_n = 1'b1;
    cycles(3);
    check_value("rst_ad_o", {16'h0, n64_ad_o}, 32'h0);
    check_value("rst_oe", n64_ad_oe, 32'h0);
    check_value("rst_req", mem_req, 32'h0);
    check_value("rst_mem_addr", {8'h0, mem_addr}, 32'h0);
    check_value("rst_underrun", underrun, 32'h0);
    reset = 1'b0;
    cycles(2);
    check_value("idle_ad_o", {16'h0, n64_ad_o}, 32'h0000_FFFF);

    // Address latch and a four-pulse burst, then a low-half-only address phase.
    set_addr(32'h1000_0040, 1'b0, 12);
    do_burst(4);
    set_addr(32'h0000_1234, 1'b1, 12);
    do_burst(1);
    check_reqs();

    // Underrun: ack held 20 clocks, read falls 8 clocks after ALE_L.
    slow_cnt = 1; slow_delay = 20;
    set_addr(32'h1000_0040, 1'b0, 4);
    read_pulse(10, 1'b1, 1'b1, 16'hFFFF, 20);
    maddr = maddr + 32'd2;
    exp_q.push_back(maddr[24:1]);
    do_burst(1);
    check_reqs();

    // Out of window, then both window edges.
    set_addr(32'h0500_0000, 1'b0, 12);
    do_burst(1);
    set_addr(32'h0FFF_FFFE, 1'b0, 12);
    do_burst(2);
    set_addr(32'h1FBF_FFFE, 1'b0, 12);
    do_burst(2);
    check_reqs();

    // Abort during DRIVE with a fetch outstanding.
    slow_cnt = 1; slow_delay = 30;
    set_addr(32'h1000_0100, 1'b0, 0);
    n64_read_n = 1'b0;
    cycles(8);
    check_value("abort_oe_before", n64_ad_oe, 32'h1);
    n64_ale_l = 1'b1; n64_ale_h = 1'b1; n64_ad_i = 16'h1000;
    cycles(5);
    check_value("abort_oe_drop", n64_ad_oe, 32'h0);
    n64_read_n = 1'b1;
    n64_ale_h = 1'b0; cycles(4);
    n64_ad_i = 16'h0200; cycles(4);
    n64_ale_l = 1'b0; cycles(4);
    maddr = 32'h1000_0200;
    exp_q.push_back(maddr[24:1]);
    cycles(60);
    do_burst(1);
    check_reqs();

    // Randomised bursts inside and below the window.
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 3) == 0)
        set_addr($urandom & 32'h0FFF_FFFE, 1'b0, 12);
      else
        set_addr(32'h1000_0000 + ($urandom_range(0, 32'h0FBF_FFF0) & 32'hFFFF_FFFE), 1'b0, 12);
      do_burst($urandom_range(1, 4));
      check_reqs();
    end

    // Reset with a request outstanding; a late ack must be ignored.
    slow_cnt = 1; slow_delay = 1000;
    set_addr(32'h1000_0300, 1'b0, 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) begin seen = 1'b1; break; end
      cycles(1);
    end
    check_value("mid_req_seen", seen, 32'h1);
    reset = 1'b1;
    cycles(1);
    check_value("mid_rst_req", mem_req, 32'h0);
    check_value("mid_rst_oe", n64_ad_oe, 32'h0);
    check_value("mid_rst_ad_o", {16'h0, n64_ad_o}, 32'h0);
    check_value("mid_rst_addr", {8'h0, mem_addr}, 32'h0);
    check_value("mid_rst_underrun", underrun, 32'h0);
    reset = 1'b0;
    cycles(2);
    force_ack = 1'b1;
    cycles(10);
    check_value("late_ack_req", mem_req, 32'h0);
    check_value("late_ack_oe", n64_ad_oe, 32'h0);
    check_value("late_ack_ad_o", {16'h0, n64_ad_o}, 32'h0000_FFFF);
    check_reqs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/n64_pi_bus_frontend.md
# n64_pi_bus_frontend

Front end between the N64 cartridge (PI) bus pins and the cart's ROM/SDRAM read port, directly upstream of the tristate AD driver in the top-level wrapper. It synchronises ALE_H/ALE_L/READ_N into the FPGA clock domain and latches the 32-bit bus address from the multiplexed AD bus. It then prefetches one halfword per read cycle over a request/acknowledge memory port and supplies the output data and output-enable for AD. Addresses auto-increment by 2 bytes per completed read, as the PI burst protocol requires.

## Interface
- MEM_AW, 24, memory halfword-address width; mem_addr = bus_addr[MEM_AW:1]
- SYNC_STAGES, 2, flops per synchroniser on ALE_H, ALE_L, READ_N and AD (minimum 2)

- clock  in  1  FPGA system clock; the only clock
- reset  in  1  synchronous, active-high reset
- n64_ad_i  in  16  AD bus as seen at the pins
- n64_ale_h  in  1  address latch enable, high half
- n64_ale_l  in  1  address latch enable, low half
- n64_read_n  in  1  PI read strobe, active low
- n64_ad_o  out  16  read data to the AD tristate driver
- n64_ad_oe  out  1  drive enable for AD; high only during a decoded read
- mem_req  out  1  memory read request; held until mem_ack
- mem_addr  out  MEM_AW  halfword address; stable while mem_req is high
- mem_ack  in  1  one-cycle pulse; mem_rdata is valid in the same cycle
- mem_rdata  in  16  memory read data
- underrun  out  1  one-cycle pulse when a read begins before its data is buffered

## Operation
- Sync: ALE_H, ALE_L and READ_N each pass through SYNC_STAGES flops. AD passes through the same depth so data stays aligned with the control signals. Edges are detected on the last stage against one further registered copy.
- Address capture:
  - ALE_H rising: enter ADDR. Invalidate the buffer and mark any in-flight request as stale.
  - ALE_H falling: addr[31:16] = synced AD.
  - ALE_L falling: addr[15:0] = synced AD. Enter PREFETCH.
- Window decode: in_window = (0x10000000 <= addr < 0x1FC00000). Recomputed whenever addr changes.
- States:
  - IDLE: waiting for ALE_H rising.
  - ADDR: address being captured.
  - PREFETCH: assert mem_req with mem_addr = addr[MEM_AW:1]. On mem_ack, load buf = mem_rdata, set buf_valid, and go to READY.
  - READY: buffer full, waiting for a READ_N falling edge.
  - DRIVE: READ_N is low.
    - On READ_N rising: addr = addr + 2 (modulo 2^32), clear buf_valid, go to PREFETCH.
- Read with an empty buffer: a READ_N falling edge seen in PREFETCH pulses underrun. The block then drives 0xFFFF while oe is high and enters DRIVE. The outstanding fetch still completes and its data is discarded. The address still advances on READ_N rising.
- Out-of-window addresses:
  - No mem_req is issued.
  - n64_ad_oe stays low.
  - READ_N edges still advance addr.
- A stale in-flight request must still be held until mem_ack. Its data is discarded, and a new request is issued only after that ack.
- n64_ad_o = buf_valid ? buf : 0xFFFF.
- n64_ad_oe = (state == DRIVE) & in_window.
- ALE_H rising in any state, including DRIVE, aborts to ADDR and drops oe on the next cycle.
- ALE_L falling without a preceding ALE_H falling in the same ADDR phase: low half is latched, high half is kept from the previous cycle.

## Timing
- Reset values:
  - n64_ad_o = 0, n64_ad_oe = 0, mem_req = 0, mem_addr = 0, underrun = 0.
  - state = IDLE, addr = 0, buf_valid = 0.
- Pin edge to internal edge detect: SYNC_STAGES + 1 clocks. Pin READ_N falling to n64_ad_oe high: SYNC_STAGES + 2 clocks (4 at default). Pin READ_N rising to oe low: same latency.
- ALE_L falling (synced) to mem_req high: 1 clock.
- mem_ack to buffer valid: 1 clock.
- Any mem_ack latency is accepted. Data is not lost as long as the ack arrives before the next synced READ_N falling edge.
- underrun is a single-cycle pulse, registered, coincident with oe rising.
- Reset asserted mid-operation:
  - All state returns to reset values on the next edge.
  - mem_req drops immediately, even with a request outstanding.
  - A mem_ack arriving after reset is ignored.
- Minimum clock is 4x the fastest PI strobe phase. Synchroniser depth plus one fetch must fit within the ALE_L-to-first-READ_N gap.

## Test plan
- Address latch: ALE_H high, AD = 0x1000 then ALE_H low, AD = 0x0040 then ALE_L low -> mem_req with mem_addr = 0x000020. Ack with data 0xBEEF; READ_N low for 10 clocks -> oe high 4 clocks after the fall, ad_o = 0xBEEF.
- Burst: four READ_N pulses from 0x10000040 -> mem_addr sequence 0x20, 0x21, 0x22, 0x23. Each pulse drives the data acked for its address.
- Underrun: ack delayed 20 clocks, READ_N falls at 8 -> underrun pulses once, ad_o = 0xFFFF, next address is 0x10000042.
- Out of window: address 0x05000000 with a READ_N pulse -> no mem_req, oe stays 0, addr advances to 0x05000002.
- Abort: ALE_H rises during DRIVE with a fetch outstanding -> oe drops. The old ack is discarded, and the new fetch uses the new address only after that ack.
- Reset: reset asserted while mem_req is high -> all outputs 0 next clock, and a later ack causes no change.
